// File: rtl/oled_spi_sink.sv
// oled_spi_sink: receiving end of the OLED SPI link.
// Synchronizes the incoming pins, deserializes MSB-first bytes, decodes the
// SSD1306 page-mode command subset and mirrors data bytes into a 512x8
// shadow frame buffer with a registered read port.
`timescale 1ns/1ps
module oled_spi_sink #(
    parameter int SYNC_STAGES  = 2,
    parameter int IDLE_TIMEOUT = 1024,
    parameter int CNT_W        = 11
) (
    input  logic       clk200M,
    input  logic       rst,
    input  logic       sclk,
    input  logic       sdin,
    input  logic       dc,
    input  logic       res_n,
    input  logic       vdd_n,
    input  logic       vbat_n,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       byte_dc,
    output logic       powered,
    output logic       disp_on,
    output logic       all_on,
    output logic [1:0] page,
    output logic [6:0] col,
    output logic       frame_done,
    output logic       err_partial,
    input  logic [8:0] rd_addr,
    output logic [7:0] rd_data
);

    localparam logic [CNT_W-1:0] IDLE_MAX  = CNT_W'(IDLE_TIMEOUT);
    // res_n synchronizer starts deasserted so a clean reset does not
    // look like a soft reset for the first few cycles.
    localparam logic [3:0]       SYNC_INIT = 4'b1000;

    typedef enum logic [1:0] {
        CMD  = 2'd0,
        ARG1 = 2'd1,
        ARG2 = 2'd2
    } dec_state_t;

    // ------------------------------------------------------------------
    // Pin synchronizers: index 0 sclk, 1 sdin, 2 dc, 3 res_n
    // ------------------------------------------------------------------
    logic [3:0]             pin_in;
    logic [SYNC_STAGES-1:0] sync_reg [4];

    assign pin_in = {res_n, dc, sdin, sclk};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sync
            // Shift each asynchronous pin through its synchronizer chain
            always_ff @(posedge clk200M) begin
                if (rst)
                    sync_reg[gi] <= {SYNC_STAGES{SYNC_INIT[gi]}};
                else
                    sync_reg[gi] <= {sync_reg[gi][SYNC_STAGES-2:0], pin_in[gi]};
            end
        end
    endgenerate

    logic sclk_s;
    logic sdin_s;
    logic dc_s;
    logic res_s;

    assign sclk_s = sync_reg[0][SYNC_STAGES-1];
    assign sdin_s = sync_reg[1][SYNC_STAGES-1];
    assign dc_s   = sync_reg[2][SYNC_STAGES-1];
    assign res_s  = sync_reg[3][SYNC_STAGES-1];

    // Soft reset from the OLED reset pin, merged with the system reset
    logic soft_rst;
    assign soft_rst = rst | ~res_s;

    // ------------------------------------------------------------------
    // Deserializer
    // ------------------------------------------------------------------
    logic             sclk_prev_reg;
    logic             rise;
    logic [7:0]       shift_reg;
    logic [2:0]       bit_cnt_reg;
    logic [CNT_W-1:0] idle_cnt_reg;
    logic             pend_reg;
    logic             pend_dc_reg;

    assign rise = sclk_s & ~sclk_prev_reg;

    // Edge detector keeps tracking through soft reset so a held-high sclk
    // is not mistaken for a fresh rising edge on release.
    always_ff @(posedge clk200M) begin
        if (rst)
            sclk_prev_reg <= 1'b0;
        else
            sclk_prev_reg <= sclk_s;
    end

    // Shift in bits on sclk rises, track idle time, flag completed bytes
    always_ff @(posedge clk200M) begin
        if (soft_rst) begin
            shift_reg    <= 8'h00;
            bit_cnt_reg  <= 3'd0;
            idle_cnt_reg <= '0;
            pend_reg     <= 1'b0;
            pend_dc_reg  <= 1'b0;
            byte_valid   <= 1'b0;
            byte_dc      <= 1'b0;
            err_partial  <= 1'b0;
        end else begin
            pend_reg    <= 1'b0;
            byte_valid  <= 1'b0;
            err_partial <= 1'b0;
            if (rise) begin
                shift_reg    <= {shift_reg[6:0], sdin_s};
                idle_cnt_reg <= '0;
                if (bit_cnt_reg == 3'd7) begin
                    bit_cnt_reg <= 3'd0;
                    pend_reg    <= 1'b1;
                    pend_dc_reg <= dc_s;
                end else begin
                    bit_cnt_reg <= bit_cnt_reg + 3'd1;
                end
            end else begin
                if (idle_cnt_reg != IDLE_MAX)
                    idle_cnt_reg <= idle_cnt_reg + CNT_W'(1);
                // Counter saturates, so this fires once per abandoned byte
                if (idle_cnt_reg == IDLE_MAX && bit_cnt_reg != 3'd0) begin
                    bit_cnt_reg <= 3'd0;
                    err_partial <= 1'b1;
                end
            end
            if (pend_reg) begin
                byte_valid <= 1'b1;
                byte_dc    <= pend_dc_reg;
            end
        end
    end

    // Received byte is held across soft reset; only system reset clears it
    always_ff @(posedge clk200M) begin
        if (rst)
            byte_data <= 8'h00;
        else if (pend_reg && res_s)
            byte_data <= shift_reg;
    end

    // Supply status straight from the enable pins
    always_ff @(posedge clk200M) begin
        if (rst)
            powered <= 1'b0;
        else
            powered <= ~vdd_n & ~vbat_n;
    end

    // ------------------------------------------------------------------
    // Command decoder
    // ------------------------------------------------------------------
    dec_state_t state_reg;
    logic [1:0] arg_cnt_reg;
    logic [7:0] arg_cmd_reg;

    // Decode one received byte per byte_valid; data bytes advance the column
    always_ff @(posedge clk200M) begin
        if (soft_rst) begin
            state_reg   <= CMD;
            arg_cnt_reg <= 2'd0;
            arg_cmd_reg <= 8'h00;
            page        <= 2'd0;
            col         <= 7'd0;
            disp_on     <= 1'b0;
            all_on      <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (byte_valid) begin
                if (byte_dc) begin
                    // Column wraps within the page; page is never advanced
                    col <= col + 7'd1;
                    if (page == 2'd3 && col == 7'd127)
                        frame_done <= 1'b1;
                end else begin
                    case (state_reg)
                        CMD: begin
                            if (byte_data[7:4] == 4'h0) begin
                                col[3:0] <= byte_data[3:0];
                            end else if (byte_data[7:3] == 5'b00010) begin
                                col[6:4] <= byte_data[2:0];
                            end else if (byte_data[7:2] == 6'b101100) begin
                                page <= byte_data[1:0];
                            end else begin
                                case (byte_data)
                                    8'hAE: disp_on <= 1'b0;
                                    8'hAF: disp_on <= 1'b1;
                                    8'hA4: all_on  <= 1'b0;
                                    8'hA5: all_on  <= 1'b1;
                                    8'h20, 8'h81, 8'h8D, 8'hA8, 8'hD3,
                                    8'hD5, 8'hD9, 8'hDA, 8'hDB: begin
                                        state_reg   <= ARG1;
                                        arg_cnt_reg <= 2'd1;
                                        arg_cmd_reg <= byte_data;
                                    end
                                    8'h21, 8'h22: begin
                                        state_reg   <= ARG1;
                                        arg_cnt_reg <= 2'd2;
                                        arg_cmd_reg <= byte_data;
                                    end
                                    default: ;
                                endcase
                            end
                        end
                        ARG1: begin
                            // Only the start address of the range commands matters
                            if (arg_cmd_reg == 8'h22)
                                page <= byte_data[1:0];
                            else if (arg_cmd_reg == 8'h21)
                                col <= byte_data[6:0];
                            if (arg_cnt_reg == 2'd2) begin
                                state_reg   <= ARG2;
                                arg_cnt_reg <= 2'd1;
                            end else begin
                                state_reg   <= CMD;
                                arg_cnt_reg <= 2'd0;
                            end
                        end
                        ARG2: begin
                            state_reg   <= CMD;
                            arg_cnt_reg <= 2'd0;
                        end
                        default: begin
                            state_reg   <= CMD;
                            arg_cnt_reg <= 2'd0;
                        end
                    endcase
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Shadow frame buffer
    // ------------------------------------------------------------------
    logic [7:0] fb_mem [512];
    logic       fb_we;

    assign fb_we = byte_valid & byte_dc & ~soft_rst;

    // Data byte lands at the current {page,col} before the column advances
    always_ff @(posedge clk200M) begin
        if (fb_we)
            fb_mem[{page, col}] <= byte_data;
    end

    // Registered read; same-address write in the same cycle returns old data
    always_ff @(posedge clk200M) begin
        if (rst)
            rd_data <= 8'h00;
        else
            rd_data <= fb_mem[rd_addr];
    end

endmodule

// File: tb/tb_oled_spi_sink.sv
// tb_oled_spi_sink: directed test of the OLED SPI sink with hand-computed
// expectations and a small frame-buffer model.
`timescale 1ns/1ps
module tb_oled_spi_sink;

    logic       clk200M = 1'b0;
    logic       rst     = 1'b1;
    logic       sclk    = 1'b0;
    logic       sdin    = 1'b0;
    logic       dc      = 1'b0;
    logic       res_n   = 1'b1;
    logic       vdd_n   = 1'b1;
    logic       vbat_n  = 1'b1;
    logic [8:0] rd_addr = 9'd0;

    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_dc;
    logic       powered;
    logic       disp_on;
    logic       all_on;
    logic [1:0] page;
    logic [6:0] col;
    logic       frame_done;
    logic       err_partial;
    logic [7:0] rd_data;

    oled_spi_sink #(
        .SYNC_STAGES (2),
        .IDLE_TIMEOUT(1024),
        .CNT_W       (11)
    ) dut (
        .clk200M    (clk200M),
        .rst        (rst),
        .sclk       (sclk),
        .sdin       (sdin),
        .dc         (dc),
        .res_n      (res_n),
        .vdd_n      (vdd_n),
        .vbat_n     (vbat_n),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_dc    (byte_dc),
        .powered    (powered),
        .disp_on    (disp_on),
        .all_on     (all_on),
        .page       (page),
        .col        (col),
        .frame_done (frame_done),
        .err_partial(err_partial),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data)
    );

    always #2.5 clk200M = ~clk200M;

    int cyc = 0;
    always @(posedge clk200M) cyc <= cyc + 1;

    // Event monitor, sampled on the falling edge
    int         bv_count  = 0;
    int         fd_count  = 0;
    int         err_count = 0;
    int         bv_cyc    = 0;
    logic [7:0] last_byte = 8'h00;
    logic       last_dc   = 1'b0;

    always @(negedge clk200M) begin
        if (byte_valid) begin
            bv_count  = bv_count + 1;
            last_byte = byte_data;
            last_dc   = byte_dc;
            bv_cyc    = cyc;
        end
        if (frame_done)  fd_count  = fd_count + 1;
        if (err_partial) err_count = err_count + 1;
    end

    int         n_checks = 0;
    int         n_fail   = 0;
    int         rise_cyc = 0;
    logic [7:0] exp_fb [512];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk200M);
        #1;
    endtask

    // Send the top nbits of val, MSB first; half is the sclk half period in clocks
    task automatic send_bits(input logic [7:0] val, input int nbits, input logic dcv, input int half);
        for (int i = 0; i < nbits; i++) begin
            sdin = val[7-i];
            dc   = dcv;
            sclk = 1'b0;
            wait_cycles(half);
            sclk     = 1'b1;
            rise_cyc = cyc;
            wait_cycles(half);
        end
    endtask

    task automatic send_byte(input logic [7:0] val, input logic dcv, input int half);
        send_bits(val, 8, dcv, half);
        wait_cycles(6);
    endtask

    task automatic read_fb(input logic [8:0] a, output logic [7:0] d);
        rd_addr = a;
        @(posedge clk200M);
        #1;
        d = rd_data;
    endtask

    function automatic logic [7:0] pat(input int p, input int c);
        return 8'((p * 53) + (c * 7) + 3);
    endfunction

    int         b0;
    int         f0;
    int         e0;
    logic [7:0] rd;
    logic [7:0] r1;
    logic [7:0] r2;
    logic       found;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        wait_cycles(5);
        check_eq("rst_byte_valid", 32'(byte_valid), 32'd0);
        check_eq("rst_byte_data", 32'(byte_data), 32'd0);
        check_eq("rst_byte_dc", 32'(byte_dc), 32'd0);
        check_eq("rst_powered", 32'(powered), 32'd0);
        check_eq("rst_disp_on", 32'(disp_on), 32'd0);
        check_eq("rst_all_on", 32'(all_on), 32'd0);
        check_eq("rst_page", 32'(page), 32'd0);
        check_eq("rst_col", 32'(col), 32'd0);
        check_eq("rst_frame_done", 32'(frame_done), 32'd0);
        check_eq("rst_err_partial", 32'(err_partial), 32'd0);
        check_eq("rst_rd_data", 32'(rd_data), 32'd0);
        rst    = 1'b0;
        vdd_n  = 1'b0;
        vbat_n = 1'b0;
        wait_cycles(3);
        check_eq("powered_on", 32'(powered), 32'd1);

        // 1: display-on command at 5 MHz sclk
        b0 = bv_count;
        send_byte(8'hAF, 1'b0, 20);
        check_eq("t1_bv_count", 32'(bv_count - b0), 32'd1);
        check_eq("t1_byte", 32'(last_byte), 32'hAF);
        check_eq("t1_dc", 32'(last_dc), 32'd0);
        check_eq("t1_latency", 32'(bv_cyc - rise_cyc), 32'd4);
        check_eq("t1_disp_on", 32'(disp_on), 32'd1);

        // 2: page address range command, then two data bytes
        send_byte(8'h22, 1'b0, 20);
        send_byte(8'h02, 1'b0, 20);
        send_byte(8'h00, 1'b0, 20);
        send_byte(8'h10, 1'b0, 20);
        send_byte(8'h5A, 1'b1, 20);
        send_byte(8'hC3, 1'b1, 20);
        exp_fb[9'h100] = 8'h5A;
        exp_fb[9'h101] = 8'hC3;
        check_eq("t2_page", 32'(page), 32'd2);
        check_eq("t2_col", 32'(col), 32'd2);
        check_eq("t2_last_dc", 32'(last_dc), 32'd1);
        read_fb(9'h100, rd);
        check_eq("t2_fb100", 32'(rd), 32'h5A);
        read_fb(9'h101, rd);
        check_eq("t2_fb101", 32'(rd), 32'hC3);

        // 3: full frame at fast sclk
        send_byte(8'h00, 1'b0, 4);
        send_byte(8'h10, 1'b0, 4);
        f0 = fd_count;
        for (int p = 0; p < 4; p++) begin
            send_byte(8'hB0 | 8'(p), 1'b0, 4);
            for (int c = 0; c < 128; c++) begin
                if (p == 3 && c == 127)
                    check_eq("t3_no_fd_early", 32'(fd_count - f0), 32'd0);
                send_byte(pat(p, c), 1'b1, 4);
                exp_fb[9'((p * 128) + c)] = pat(p, c);
            end
        end
        check_eq("t3_frame_done", 32'(fd_count - f0), 32'd1);
        check_eq("t3_col_wrap", 32'(col), 32'd0);
        check_eq("t3_page", 32'(page), 32'd3);
        for (int a = 0; a < 512; a++) begin
            read_fb(9'(a), rd);
            check_eq($sformatf("t3_fb_%03h", a), 32'(rd), 32'(exp_fb[a]));
        end

        // 4: partial byte abandoned by idle timeout
        e0 = err_count;
        b0 = bv_count;
        send_bits(8'hF8, 5, 1'b0, 20);
        wait_cycles(1100);
        check_eq("t4_err_pulse", 32'(err_count - e0), 32'd1);
        check_eq("t4_no_bv", 32'(bv_count - b0), 32'd0);
        send_byte(8'hA5, 1'b0, 20);
        check_eq("t4_bv_count", 32'(bv_count - b0), 32'd1);
        check_eq("t4_byte", 32'(last_byte), 32'hA5);
        check_eq("t4_all_on", 32'(all_on), 32'd1);
        check_eq("t4_err_once", 32'(err_count - e0), 32'd1);

        // 5: soft reset mid-argument and mid-byte
        send_byte(8'h05, 1'b0, 20);
        send_byte(8'hAE, 1'b0, 20);
        check_eq("t5_col_pre", 32'(col), 32'd5);
        check_eq("t5_disp_off", 32'(disp_on), 32'd0);
        send_byte(8'h81, 1'b0, 20);
        e0 = err_count;
        b0 = bv_count;
        send_bits(8'h81, 3, 1'b0, 20);
        res_n = 1'b0;
        wait_cycles(10);
        check_eq("t5_page_rst", 32'(page), 32'd0);
        check_eq("t5_col_rst", 32'(col), 32'd0);
        check_eq("t5_all_on_rst", 32'(all_on), 32'd0);
        check_eq("t5_no_bv", 32'(bv_count - b0), 32'd0);
        res_n = 1'b1;
        wait_cycles(10);
        send_byte(8'hAF, 1'b0, 20);
        check_eq("t5_bv_count", 32'(bv_count - b0), 32'd1);
        check_eq("t5_byte", 32'(last_byte), 32'hAF);
        check_eq("t5_disp_on", 32'(disp_on), 32'd1);
        check_eq("t5_no_err", 32'(err_count - e0), 32'd0);
        read_fb(9'h000, rd);
        check_eq("t5_fb000", 32'(rd), 32'(exp_fb[0]));
        read_fb(9'h17F, rd);
        check_eq("t5_fb17f", 32'(rd), 32'(exp_fb[9'h17F]));
        read_fb(9'h1FF, rd);
        check_eq("t5_fb1ff", 32'(rd), 32'(exp_fb[9'h1FF]));

        // 6: read-during-write at {1,5}
        send_byte(8'hB1, 1'b0, 20);
        send_byte(8'h05, 1'b0, 20);
        send_byte(8'h10, 1'b0, 20);
        rd_addr = 9'h085;
        wait_cycles(3);
        found = 1'b0;
        r1    = 8'h00;
        r2    = 8'h00;
        fork
            send_byte(8'h77, 1'b1, 20);
            begin
                for (int i = 0; i < 2000 && !found; i++) begin
                    @(negedge clk200M);
                    if (byte_valid) found = 1'b1;
                end
                if (found) begin
                    @(negedge clk200M);
                    r1 = rd_data;
                    @(negedge clk200M);
                    r2 = rd_data;
                end
            end
        join
        check_eq("t6_bv_seen", 32'(found), 32'd1);
        check_eq("t6_old_data", 32'(r1), 32'(exp_fb[9'h085]));
        check_eq("t6_new_data", 32'(r2), 32'h77);
        check_eq("t6_col", 32'(col), 32'd6);
        check_eq("t6_page", 32'(page), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
